// File: rtl/sdram_arbiter_if.sv
// Bundle of client-side and controller-side signals around the SDRAM arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the clients and the controller.
interface sdram_arbiter_if #(
  parameter int NUM_CLI = 4,
  parameter int AW      = 24
);
  logic                  sdram_init_done;
  logic [NUM_CLI-1:0]    cli_req;
  logic [NUM_CLI-1:0]    cli_wr;
  logic [NUM_CLI*AW-1:0] cli_addr;
  logic [NUM_CLI*10-1:0] cli_burst;
  logic [NUM_CLI-1:0]    cli_grant;
  logic [NUM_CLI-1:0]    cli_ack;
  logic [NUM_CLI-1:0]    cli_done;
  logic [NUM_CLI-1:0]    cli_err;
  logic                  sdram_wr_req;
  logic                  sdram_rd_req;
  logic                  sdram_wr_ack;
  logic                  sdram_rd_ack;
  logic [AW-1:0]         sdram_addr;
  logic [9:0]            sdram_wr_burst;
  logic [9:0]            sdram_rd_burst;
  logic                  busy;
  logic [2:0]            owner;

  modport slave (
    input  sdram_init_done, cli_req, cli_wr, cli_addr, cli_burst,
           sdram_wr_ack, sdram_rd_ack,
    output cli_grant, cli_ack, cli_done, cli_err,
           sdram_wr_req, sdram_rd_req, sdram_addr,
           sdram_wr_burst, sdram_rd_burst, busy, owner
  );

  modport master (
    output sdram_init_done, cli_req, cli_wr, cli_addr, cli_burst,
           sdram_wr_ack, sdram_rd_ack,
    input  cli_grant, cli_ack, cli_done, cli_err,
           sdram_wr_req, sdram_rd_req, sdram_addr,
           sdram_wr_burst, sdram_rd_burst, busy, owner
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between NUM_CLI burst requesters.
// One transaction at a time: IDLE -> REQ (wait for ack, with timeout) -> XFER (wait for ack to fall) -> IDLE.
module sdram_arbiter #(
  parameter int NUM_CLI     = 4,
  parameter int AW          = 24,
  parameter int REQ_TIMEOUT = 1023
) (
  input logic            clk,
  input logic            rst,
  sdram_arbiter_if.slave bus
);

  localparam int BW = 10;
  localparam int CW = 10;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;

  state_e             state_q, state_d;
  logic [2:0]         owner_q, owner_d;
  logic               wr_q, wr_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic               wr_req_q, wr_req_d;
  logic               rd_req_q, rd_req_d;
  logic [NUM_CLI-1:0] grant_q, grant_d;
  logic [NUM_CLI-1:0] done_q, done_d;
  logic [NUM_CLI-1:0] err_q, err_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  int                 win_idx;
  logic               win_vld;
  logic               arb_en;
  logic               match_ack;
  logic               any_ack;
  logic               win_wr;
  logic [AW-1:0]      win_addr;
  logic [BW-1:0]      win_burst;

  // Rotating priority: the search begins just after the last owner, so the last owner ranks lowest.
  always_comb begin
    int idx;
    win_idx = 0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_CLI; k++) begin
      idx = int'(owner_q) + k;
      if (idx >= NUM_CLI) idx = idx - NUM_CLI;
      if (!win_vld && bus.cli_req[idx]) begin
        win_idx = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign win_wr    = bus.cli_wr[win_idx];
  assign win_addr  = bus.cli_addr[win_idx*AW +: AW];
  assign win_burst = bus.cli_burst[win_idx*BW +: BW];

  // A done or err pulse blocks arbitration for that cycle, leaving at least one idle cycle.
  assign arb_en    = (state_q == IDLE) && bus.sdram_init_done && win_vld
                     && !(|done_q) && !(|err_q);
  assign match_ack = wr_q ? bus.sdram_wr_ack : bus.sdram_rd_ack;
  assign any_ack   = bus.sdram_wr_ack | bus.sdram_rd_ack;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 3'(NUM_CLI - 1);
      wr_q     <= 1'b0;
      addr_q   <= '0;
      burst_q  <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    grant_d  = '0;
    done_d   = '0;
    err_d    = '0;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (arb_en) begin
          owner_d          = 3'(win_idx);
          wr_d             = win_wr;
          addr_d           = win_addr;
          burst_d          = win_burst;
          grant_d[win_idx] = 1'b1;
          if (win_burst != '0) begin
            state_d  = REQ;
            wr_req_d = win_wr;
            rd_req_d = !win_wr;
            cnt_d    = '0;
          end else begin
            err_d[win_idx] = 1'b1;
          end
        end
      end

      REQ: begin
        if (match_ack) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          state_d  = XFER;
        end else if (cnt_q == CW'(REQ_TIMEOUT - 1)) begin
          wr_req_d       = 1'b0;
          rd_req_d       = 1'b0;
          err_d[owner_q] = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      XFER: begin
        if (!match_ack) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The ack is forwarded without a register so client data stays aligned with the controller.
  always_comb begin
    bus.cli_grant      = grant_q;
    bus.cli_done       = done_q;
    bus.cli_err        = err_q;
    bus.sdram_wr_req   = wr_req_q;
    bus.sdram_rd_req   = rd_req_q;
    bus.sdram_addr     = addr_q;
    bus.sdram_wr_burst = burst_q;
    bus.sdram_rd_burst = burst_q;
    bus.busy           = (state_q != IDLE);
    bus.owner          = owner_q;
    bus.cli_ack        = '0;
    for (int i = 0; i < NUM_CLI; i++) begin
      bus.cli_ack[i] = (state_q != IDLE) && (owner_q == 3'(i)) && any_ack;
    end
  end

  a_req_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(wr_req_q && rd_req_q));

  a_pulses_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant_q) && $onehot0(done_q) && $onehot0(err_q));

  a_idle_no_req: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> !(wr_req_q || rd_req_q));

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus queues expected grant/err/done events,
// a monitor pops and compares them whenever the arbiter pulses, and a small controller model acks requests.
module tb_sdram_arbiter;

  localparam int NCLI = 4;
  localparam int AW   = 24;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.NUM_CLI(NCLI), .AW(AW)) bus ();

  sdram_arbiter #(.NUM_CLI(NCLI), .AW(AW), .REQ_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {EV_GRANT, EV_ERR, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e      kind;
    int            idx;
    bit            wr;
    logic [AW-1:0] addr;
    int            burst;
  } ev_t;

  ev_t exp_q[$];
  int  checks      = 0;
  int  errors      = 0;
  int  grant_total = 0;
  int  req_cycles  = 0;
  int  ack_cnt[NCLI] = '{default: 0};
  bit  no_ack      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input int i, input bit wr,
                         input logic [AW-1:0] addr, input int burst);
    ev_t e;
    e.kind  = k;
    e.idx   = i;
    e.wr    = wr;
    e.addr  = addr;
    e.burst = burst;
    exp_q.push_back(e);
  endtask

  task automatic set_cli(input int i, input bit wr, input logic [AW-1:0] addr, input int burst);
    bus.cli_wr[i]              = wr;
    bus.cli_addr[i*AW +: AW]   = addr;
    bus.cli_burst[i*10 +: 10]  = 10'(burst);
  endtask

  // Controller model: ack 3 cycles after a request is seen, held for burst cycles.
  initial begin
    int  dly;
    int  rem;
    bit  ack_on;
    dly = 0;
    rem = 0;
    ack_on = 1'b0;
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.sdram_wr_ack = 1'b0;
        bus.sdram_rd_ack = 1'b0;
        ack_on = 1'b0;
        dly = 0;
      end else if (ack_on) begin
        rem--;
        if (rem == 0) begin
          ack_on = 1'b0;
          bus.sdram_wr_ack = 1'b0;
          bus.sdram_rd_ack = 1'b0;
        end
      end else if ((bus.sdram_wr_req || bus.sdram_rd_req) && !no_ack) begin
        dly++;
        if (dly == 3) begin
          dly = 0;
          ack_on = 1'b1;
          if (bus.sdram_wr_req) begin
            bus.sdram_wr_ack = 1'b1;
            rem = int'(bus.sdram_wr_burst);
          end else begin
            bus.sdram_rd_ack = 1'b1;
            rem = int'(bus.sdram_rd_burst);
          end
        end
      end else begin
        dly = 0;
      end
    end
  end

  task automatic match_ev(input ev_kind_e k, input int i);
    ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_event_kind%0d_cli%0d", int'(k), i), 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 64'(int'(k)), 64'(int'(e.kind)));
    check("event_client", 64'(i), 64'(e.idx));
    if (k == EV_GRANT) begin
      check("grant_owner", 64'(bus.owner), 64'(i));
      if (e.burst != 0) begin
        check("grant_wr_req", 64'(bus.sdram_wr_req), 64'(e.wr));
        check("grant_rd_req", 64'(bus.sdram_rd_req), 64'(!e.wr));
        check("grant_addr", 64'(bus.sdram_addr), 64'(e.addr));
        check("grant_burst", 64'(e.wr ? bus.sdram_wr_burst : bus.sdram_rd_burst), 64'(e.burst));
      end else begin
        check("zero_burst_no_req", 64'({bus.sdram_wr_req, bus.sdram_rd_req}), 64'(0));
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("exclusive_outputs",
              64'({$onehot0(bus.cli_grant), $onehot0(bus.cli_done), $onehot0(bus.cli_err),
                   !(bus.sdram_wr_req && bus.sdram_rd_req)}), 64'hF);
        if (bus.sdram_wr_req || bus.sdram_rd_req) req_cycles++;
        for (int i = 0; i < NCLI; i++) if (bus.cli_grant[i]) begin grant_total++; match_ev(EV_GRANT, i); end
        for (int i = 0; i < NCLI; i++) if (bus.cli_err[i]) match_ev(EV_ERR, i);
        for (int i = 0; i < NCLI; i++) if (bus.cli_done[i]) match_ev(EV_DONE, i);
        for (int i = 0; i < NCLI; i++) if (bus.cli_ack[i]) ack_cnt[i]++;
      end
    end
  end

  task automatic wait_grant(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(posedge clk);
      #1;
      if (bus.cli_grant[i]) ok = 1'b1;
    end
    check($sformatf("grant%0d_within_budget", i), 64'(ok), 64'(1));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("events_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g0, r0, a0, k, n, len;
    bus.sdram_init_done = 1'b0;
    bus.cli_req   = '0;
    bus.cli_wr    = '0;
    bus.cli_addr  = '0;
    bus.cli_burst = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_pulses", 64'({bus.cli_grant, bus.cli_done, bus.cli_err, bus.cli_ack}), 64'(0));
    check("reset_sdram", 64'({bus.sdram_wr_req, bus.sdram_rd_req, bus.sdram_addr,
                              bus.sdram_wr_burst, bus.sdram_rd_burst, bus.busy}), 64'(0));
    check("reset_owner", 64'(bus.owner), 64'(NCLI - 1));

    // 1: init gate
    @(negedge clk);
    set_cli(0, 1'b0, 24'h000040, 4);
    bus.cli_req = 4'b0001;
    g0 = grant_total;
    r0 = req_cycles;
    repeat (50) @(negedge clk);
    check("init_gate_grants", 64'(grant_total - g0), 64'(0));
    check("init_gate_reqs", 64'(req_cycles - r0), 64'(0));
    push_ev(EV_GRANT, 0, 1'b0, 24'h000040, 4);
    push_ev(EV_DONE,  0, 1'b0, 24'h000040, 4);
    bus.sdram_init_done = 1'b1;
    @(posedge clk);
    #1;
    check("init_grant_next_edge", 64'(bus.cli_grant), 64'(4'b0001));
    bus.cli_req = '0;
    drain(200);

    // 2: write burst on client 1
    set_cli(1, 1'b1, 24'h000100, 8);
    a0 = ack_cnt[1];
    push_ev(EV_GRANT, 1, 1'b1, 24'h000100, 8);
    push_ev(EV_DONE,  1, 1'b1, 24'h000100, 8);
    bus.cli_req = 4'b0010;
    wait_grant(1);
    bus.cli_req = '0;
    drain(200);
    check("write_ack_cycles", 64'(ack_cnt[1] - a0), 64'(8));

    // 3: round robin from a fresh reset, all clients requesting
    do_reset();
    set_cli(0, 1'b1, 24'h001000, 4);
    set_cli(1, 1'b0, 24'h002000, 4);
    set_cli(2, 1'b1, 24'h003000, 4);
    set_cli(3, 1'b0, 24'h004000, 4);
    for (int j = 0; j < 5; j++) begin
      int c;
      c = j % NCLI;
      push_ev(EV_GRANT, c, (c % 2) == 0, 24'(32'h1000 * (c + 1)), 4);
      push_ev(EV_DONE,  c, (c % 2) == 0, 24'(32'h1000 * (c + 1)), 4);
    end
    bus.cli_req = 4'b1111;
    k = 0;
    n = 0;
    while (k < 5 && n < 1000) begin
      @(posedge clk);
      #1;
      if (|bus.cli_grant) k++;
      n++;
    end
    bus.cli_req = '0;
    check("round_robin_grants", 64'(k), 64'(5));
    drain(300);

    // 4: timeout, then the next waiting client is served
    no_ack = 1'b1;
    set_cli(1, 1'b0, 24'h005000, 4);
    set_cli(2, 1'b0, 24'h006000, 4);
    push_ev(EV_GRANT, 1, 1'b0, 24'h005000, 4);
    push_ev(EV_ERR,   1, 1'b0, 24'h005000, 4);
    push_ev(EV_GRANT, 2, 1'b0, 24'h006000, 4);
    push_ev(EV_ERR,   2, 1'b0, 24'h006000, 4);
    bus.cli_req = 4'b0110;
    wait_grant(1);
    bus.cli_req[1] = 1'b0;
    len = 0;
    while (bus.sdram_rd_req && len < 100) begin
      len++;
      @(posedge clk);
      #1;
    end
    check("timeout_req_cycles", 64'(len), 64'(TMO));
    check("timeout_err_pulse", 64'(bus.cli_err), 64'(4'b0010));
    wait_grant(2);
    bus.cli_req = '0;
    drain(200);
    no_ack = 1'b0;

    // 5: zero-length read rejected in the grant cycle
    set_cli(2, 1'b0, 24'h007000, 0);
    push_ev(EV_GRANT, 2, 1'b0, 24'h007000, 0);
    push_ev(EV_ERR,   2, 1'b0, 24'h007000, 0);
    bus.cli_req = 4'b0100;
    wait_grant(2);
    check("zero_burst_err_with_grant", 64'(bus.cli_err), 64'(4'b0100));
    check("zero_burst_not_busy", 64'(bus.busy), 64'(0));
    bus.cli_req = '0;
    drain(50);

    // 6: reset in the middle of client 3's transfer
    set_cli(3, 1'b1, 24'h008000, 8);
    push_ev(EV_GRANT, 3, 1'b1, 24'h008000, 8);
    bus.cli_req = 4'b1000;
    wait_grant(3);
    bus.cli_req = '0;
    n = 0;
    while (!bus.cli_ack[3] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("xfer_ack_seen", 64'(bus.cli_ack[3]), 64'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midxfer_reset_pulses", 64'({bus.cli_grant, bus.cli_done, bus.cli_err, bus.cli_ack}), 64'(0));
    check("midxfer_reset_sdram", 64'({bus.sdram_wr_req, bus.sdram_rd_req, bus.sdram_addr,
                                      bus.sdram_wr_burst, bus.sdram_rd_burst, bus.busy}), 64'(0));
    check("midxfer_reset_owner", 64'(bus.owner), 64'(NCLI - 1));
    check("midxfer_no_pending", 64'(exp_q.size()), 64'(0));
    set_cli(0, 1'b0, 24'h009000, 2);
    bus.cli_req = 4'b1001;
    push_ev(EV_GRANT, 0, 1'b0, 24'h009000, 2);
    push_ev(EV_DONE,  0, 1'b0, 24'h009000, 2);
    @(negedge clk);
    rst = 1'b0;
    wait_grant(0);
    bus.cli_req = '0;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
